stopwatch_up_counter_mmss: RTL and testbench

- Up-counting min:sec BCD stopwatch (00:00 to 59:59).
- Counterpart to the loadable 60-step down counter used by the cook timer.
- Consumes the 1 ms strobe from the divider chain and derives whole seconds internally, so the first second after start is exact.
- Drives the 4-digit FND display path and provides start/stop, pause, lap-freeze and clear control.

---
 rtl/stopwatch_up_counter_mmss.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_up_counter_mmss.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_up_counter_mmss.sv
// Up-counting MM:SS BCD stopwatch driven by a 1 ms strobe, with start/stop,
// pause, lap-freeze and clear; whole seconds are derived internally.
module stopwatch_up_counter_mmss #(
   parameter int MSEC_PER_SEC = 1000,
   parameter int SUB_W        = 10
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       clk_msec,
   input  logic       btn_start_stop,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic [3:0] min10,
   output logic [3:0] min1,
   output logic [3:0] sec10,
   output logic [3:0] sec1,
   output logic       running,
   output logic       lap_active,
   output logic       hour_clk
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(MSEC_PER_SEC - 1);

   state_t           state_q, state_d;
   logic [SUB_W-1:0] sub_q, sub_d;
   logic [3:0]       min10_q, min10_d, min1_q, min1_d;
   logic [3:0]       sec10_q, sec10_d, sec1_q, sec1_d;
   logic [3:0]       lap_min10_q, lap_min10_d, lap_min1_q, lap_min1_d;
   logic [3:0]       lap_sec10_q, lap_sec10_d, lap_sec1_q, lap_sec1_d;
   logic             lap_active_q, lap_active_d;
   logic             hour_clk_q, hour_clk_d;
   logic             sec_tick;
   logic             lap_toggle;

   always_comb begin
      state_d      = state_q;
      sub_d        = sub_q;
      min10_d      = min10_q;
      min1_d       = min1_q;
      sec10_d      = sec10_q;
      sec1_d       = sec1_q;
      lap_min10_d  = lap_min10_q;
      lap_min1_d   = lap_min1_q;
      lap_sec10_d  = lap_sec10_q;
      lap_sec1_d   = lap_sec1_q;
      lap_active_d = lap_active_q;
      hour_clk_d   = 1'b0;
      sec_tick     = 1'b0;
      lap_toggle   = 1'b0;

      // Only the highest-priority button that is legal in the current state acts.
      case (state_q)
         IDLE: begin
            if (btn_clear) begin
               state_d = IDLE;
            end else if (btn_start_stop) begin
               state_d = RUN;
               sub_d   = '0;
            end
         end
         RUN: begin
            if (clk_msec) begin
               if (sub_q >= SUB_MAX) begin
                  sub_d    = '0;
                  sec_tick = 1'b1;
               end else begin
                  sub_d = sub_q + SUB_W'(1);
               end
            end
            if (btn_start_stop) begin
               state_d = PAUSE;
            end else if (btn_lap) begin
               lap_toggle = 1'b1;
            end
         end
         PAUSE: begin
            if (btn_clear) begin
               state_d      = IDLE;
               sub_d        = '0;
               min10_d      = '0;
               min1_d       = '0;
               sec10_d      = '0;
               sec1_d       = '0;
               lap_min10_d  = '0;
               lap_min1_d   = '0;
               lap_sec10_d  = '0;
               lap_sec1_d   = '0;
               lap_active_d = 1'b0;
            end else if (btn_start_stop) begin
               state_d = RUN;
            end else if (btn_lap) begin
               lap_toggle = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Lap capture reads the registered digits, so a coincident tick is not seen.
      if (lap_toggle) begin
         if (!lap_active_q) begin
            lap_min10_d  = min10_q;
            lap_min1_d   = min1_q;
            lap_sec10_d  = sec10_q;
            lap_sec1_d   = sec1_q;
            lap_active_d = 1'b1;
         end else begin
            lap_active_d = 1'b0;
         end
      end

      if (sec_tick) begin
         if (sec1_q < 4'd9) begin
            sec1_d = sec1_q + 4'd1;
         end else begin
            sec1_d = 4'd0;
            if (sec10_q < 4'd5) begin
               sec10_d = sec10_q + 4'd1;
            end else begin
               sec10_d = 4'd0;
               if (min1_q < 4'd9) begin
                  min1_d = min1_q + 4'd1;
               end else begin
                  min1_d = 4'd0;
                  if (min10_q < 4'd5) begin
                     min10_d = min10_q + 4'd1;
                  end else begin
                     min10_d    = 4'd0;
                     hour_clk_d = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q      <= IDLE;
         sub_q        <= '0;
         min10_q      <= '0;
         min1_q       <= '0;
         sec10_q      <= '0;
         sec1_q       <= '0;
         lap_min10_q  <= '0;
         lap_min1_q   <= '0;
         lap_sec10_q  <= '0;
         lap_sec1_q   <= '0;
         lap_active_q <= 1'b0;
         hour_clk_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sub_q        <= sub_d;
         min10_q      <= min10_d;
         min1_q       <= min1_d;
         sec10_q      <= sec10_d;
         sec1_q       <= sec1_d;
         lap_min10_q  <= lap_min10_d;
         lap_min1_q   <= lap_min1_d;
         lap_sec10_q  <= lap_sec10_d;
         lap_sec1_q   <= lap_sec1_d;
         lap_active_q <= lap_active_d;
         hour_clk_q   <= hour_clk_d;
      end
   end

   assign min10      = lap_active_q ? lap_min10_q : min10_q;
   assign min1       = lap_active_q ? lap_min1_q  : min1_q;
   assign sec10      = lap_active_q ? lap_sec10_q : sec10_q;
   assign sec1       = lap_active_q ? lap_sec1_q  : sec1_q;
   assign running    = (state_q == RUN);
   assign lap_active = lap_active_q;
   assign hour_clk   = hour_clk_q;

endmodule

// File: tb/tb_stopwatch_up_counter_mmss.sv
// Bench for the MM:SS stopwatch: directed scenarios plus random button/strobe
// traffic checked against a seconds-count reference model.
module tb_stopwatch_up_counter_mmss;

   localparam int MSEC = 4;

   logic       clk = 1'b0;
   logic       reset_p;
   logic       clk_msec;
   logic       btn_start_stop;
   logic       btn_lap;
   logic       btn_clear;
   logic [3:0] min10, min1, sec10, sec1;
   logic       running, lap_active, hour_clk;
   logic [18:0] obs;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 idle, 1 run, 2 pause; time kept as plain seconds.
   int m_state, m_ms, m_secs, m_lap_secs;
   bit m_lap_on, m_hour;

   stopwatch_up_counter_mmss #(.MSEC_PER_SEC(MSEC), .SUB_W(3)) dut (
      .clk(clk), .reset_p(reset_p), .clk_msec(clk_msec),
      .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
      .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
      .running(running), .lap_active(lap_active), .hour_clk(hour_clk)
   );

   always #5 clk = ~clk;

   assign obs = {min10, min1, sec10, sec1, running, lap_active, hour_clk};

   task automatic model_reset();
      m_state = 0; m_ms = 0; m_secs = 0; m_lap_secs = 0; m_lap_on = 0; m_hour = 0;
   endtask

   task automatic model_step(input bit ss, input bit lp, input bit cl, input bit ms);
      int old_secs;
      old_secs = m_secs;
      m_hour = 0;
      case (m_state)
         0: if (!cl && ss) begin m_state = 1; m_ms = 0; end
         1: begin
            if (ms) begin
               m_ms++;
               if (m_ms == MSEC) begin
                  m_ms = 0;
                  m_secs = (m_secs + 1) % 3600;
                  if (m_secs == 0) m_hour = 1;
               end
            end
            if (ss) m_state = 2;
            else if (lp) begin
               if (!m_lap_on) begin m_lap_secs = old_secs; m_lap_on = 1; end
               else m_lap_on = 0;
            end
         end
         default: begin
            if (cl) begin
               m_state = 0; m_ms = 0; m_secs = 0; m_lap_secs = 0; m_lap_on = 0;
            end else if (ss) m_state = 1;
            else if (lp) begin
               if (!m_lap_on) begin m_lap_secs = old_secs; m_lap_on = 1; end
               else m_lap_on = 0;
            end
         end
      endcase
   endtask

   function automatic logic [18:0] exp_vec();
      int d, mm, s;
      d  = m_lap_on ? m_lap_secs : m_secs;
      mm = d / 60;
      s  = d % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(s / 10), 4'(s % 10),
              1'(m_state == 1), 1'(m_lap_on), 1'(m_hour)};
   endfunction

   task automatic cyc(input bit ss, input bit lp, input bit cl, input bit ms);
      btn_start_stop = ss; btn_lap = lp; btn_clear = cl; clk_msec = ms;
      @(posedge clk); #1;
      btn_start_stop = 0; btn_lap = 0; btn_clear = 0; clk_msec = 0;
      model_step(ss, lp, cl, ms);
   endtask

   task automatic run_secs(input int n);
      for (int i = 0; i < n * MSEC; i++) cyc(0, 0, 0, 1);
   endtask

   task automatic test_reset();
      reset_p = 1; clk_msec = 0; btn_start_stop = 0; btn_lap = 0; btn_clear = 0;
      model_reset();
      #23;
      checks++;
      if (obs !== 19'd0) begin
         errors++; $display("FAIL reset_outputs got=%h want=%h", obs, 19'd0);
      end
      reset_p = 0;
      #3;
      cyc(0, 0, 1, 1);
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL idle_clear_msec got=%h want=%h", obs, exp_vec());
      end
   endtask

   task automatic test_first_second();
      cyc(1, 0, 0, 0);
      for (int i = 0; i < MSEC - 1; i++) cyc(0, 0, 0, 1);
      checks++;
      if (obs[18:3] !== 16'h0000 || running !== 1'b1) begin
         errors++; $display("FAIL first_sec_pre got=%h want=0000 run=1", obs[18:3]);
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0001, 3'b100}) begin
         errors++; $display("FAIL first_sec got=%h want=%h", obs, {16'h0001, 3'b100});
      end
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL first_sec_model got=%h want=%h", obs, exp_vec());
      end
   endtask

   task automatic test_carries();
      run_secs(8);
      checks++;
      if (obs[18:3] !== 16'h0009) begin
         errors++; $display("FAIL carry_0009 got=%h want=0009", obs[18:3]);
      end
      run_secs(1);
      checks++;
      if (obs[18:3] !== 16'h0010) begin
         errors++; $display("FAIL carry_0010 got=%h want=0010", obs[18:3]);
      end
      run_secs(589);
      checks++;
      if (obs[18:3] !== 16'h0959) begin
         errors++; $display("FAIL carry_0959 got=%h want=0959", obs[18:3]);
      end
      run_secs(1);
      checks++;
      if (obs !== {16'h1000, 3'b100}) begin
         errors++; $display("FAIL carry_1000 got=%h want=%h", obs, {16'h1000, 3'b100});
      end
   endtask

   task automatic test_wrap();
      run_secs(2999);
      checks++;
      if (obs !== {16'h5959, 3'b100}) begin
         errors++; $display("FAIL wrap_5959 got=%h want=%h", obs, {16'h5959, 3'b100});
      end
      for (int i = 0; i < MSEC - 1; i++) cyc(0, 0, 0, 1);
      checks++;
      if (hour_clk !== 1'b0 || obs[18:3] !== 16'h5959) begin
         errors++; $display("FAIL wrap_pre got=%h hour=%b want=5959 hour=0", obs[18:3], hour_clk);
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0000, 3'b101}) begin
         errors++; $display("FAIL wrap_hour got=%h want=%h", obs, {16'h0000, 3'b101});
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (obs !== {16'h0000, 3'b100}) begin
         errors++; $display("FAIL wrap_hour_1clk got=%h want=%h", obs, {16'h0000, 3'b100});
      end
   endtask

   task automatic test_lap();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      checks++;
      if (obs !== exp_vec() || obs !== 19'd0) begin
         errors++; $display("FAIL lap_clear_idle got=%h want=%h", obs, 19'd0);
      end
      cyc(1, 0, 0, 0);
      run_secs(5);
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 2 * MSEC; i++) cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0005, 3'b110}) begin
         errors++; $display("FAIL lap_hold got=%h want=%h", obs, {16'h0005, 3'b110});
      end
      cyc(0, 1, 0, 0);
      checks++;
      if (obs !== {16'h0007, 3'b100}) begin
         errors++; $display("FAIL lap_release got=%h want=%h", obs, {16'h0007, 3'b100});
      end
   endtask

   task automatic test_pause();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0);
      run_secs(3);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0003, 3'b000}) begin
         errors++; $display("FAIL pause_hold got=%h want=%h", obs, {16'h0003, 3'b000});
      end
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 1);
      checks++;
      if (obs[18:3] !== 16'h0003) begin
         errors++; $display("FAIL resume_pre got=%h want=0003", obs[18:3]);
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0004, 3'b100}) begin
         errors++; $display("FAIL resume got=%h want=%h", obs, {16'h0004, 3'b100});
      end
   endtask

   task automatic test_clear_priority();
      cyc(0, 0, 1, 0);
      checks++;
      if (obs !== {16'h0004, 3'b100}) begin
         errors++; $display("FAIL run_clear_ignored got=%h want=%h", obs, {16'h0004, 3'b100});
      end
      for (int i = 0; i < MSEC - 1; i++) cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      checks++;
      if (obs !== {16'h0005, 3'b000}) begin
         errors++; $display("FAIL msec_with_stop got=%h want=%h", obs, {16'h0005, 3'b000});
      end
      cyc(0, 1, 0, 0);
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL pause_lap got=%h want=%h", obs, exp_vec());
      end
      cyc(1, 1, 1, 0);
      checks++;
      if (obs !== 19'd0) begin
         errors++; $display("FAIL clear_priority got=%h want=%h", obs, 19'd0);
      end
   endtask

   task automatic test_reset_midrun();
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 2 * MSEC + 1; i++) cyc(0, 0, 0, 1);
      reset_p = 1;
      #1;
      model_reset();
      checks++;
      if (obs !== 19'd0) begin
         errors++; $display("FAIL async_reset got=%h want=%h", obs, 19'd0);
      end
      #2 reset_p = 0;
      cyc(1, 0, 0, 0);
      for (int i = 0; i < MSEC - 1; i++) cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0000, 3'b100}) begin
         errors++; $display("FAIL fresh_sec_pre got=%h want=%h", obs, {16'h0000, 3'b100});
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (obs !== {16'h0001, 3'b100}) begin
         errors++; $display("FAIL fresh_sec got=%h want=%h", obs, {16'h0001, 3'b100});
      end
   endtask

   task automatic test_random();
      bit ss, lp, cl, ms;
      for (int i = 0; i < 4000; i++) begin
         ms = ($urandom_range(0, 3) != 0);
         ss = ($urandom_range(0, 19) == 0);
         lp = ($urandom_range(0, 11) == 0);
         cl = ($urandom_range(0, 15) == 0);
         cyc(ss, lp, cl, ms);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random_cyc%0d got=%h want=%h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_second();
      test_carries();
      test_wrap();
      test_lap();
      test_pause();
      test_clear_priority();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
